// File: rtl/ejection_buffer_if.sv
// Flit handshake bundle between the reduction tree, the ejection buffer and the local PE.
// The buffer takes the slave view; the producer/consumer side takes the master view.
interface ejection_buffer_if #(
    parameter int FLIT_SIZE = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [FLIT_SIZE-1:0] in;
    logic                 in_valid;
    logic                 in_avail;
    logic [FLIT_SIZE-1:0] out;
    logic                 out_valid;
    logic                 out_avail;
    logic [OCC_W-1:0]     occupancy;
    logic [CNT_W-1:0]     flit_cnt;

    modport slave (
        input  in, in_valid, out_avail,
        output in_avail, out, out_valid, occupancy, flit_cnt
    );

    modport master (
        output in, in_valid, out_avail,
        input  in_avail, out, out_valid, occupancy, flit_cnt
    );
endinterface

// File: rtl/ejection_buffer.sv
// Elastic FIFO between the reduction tree and the PE ejection port: a registered head
// flit backed by a circular store, with occupancy and accepted-flit count for perf monitoring.
module ejection_buffer #(
    parameter int FLIT_SIZE = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    ejection_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [FLIT_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [OCC_W-1:0]     st_cnt;
    logic [FLIT_SIZE-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_avail_q, in_avail_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic push, pop, head_free, st_empty, st_rd, st_wr, bypass;

    assign push      = bus.in_valid && in_avail_q;
    assign pop       = out_valid_q && bus.out_avail;
    // Flits in the circular store exclude the one sitting in the head register.
    assign st_cnt    = occ_q - OCC_W'(out_valid_q);
    assign st_empty  = (st_cnt == '0);
    assign head_free = !out_valid_q || pop;
    assign st_rd     = head_free && !st_empty;
    assign bypass    = push && head_free && st_empty;
    assign st_wr     = push && !bypass;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (head_free) begin
            if (st_rd) begin
                out_d       = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
            end else if (push) begin
                out_d       = bus.in;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        rd_ptr_d   = rd_ptr_q + PTR_W'(st_rd);
        wr_ptr_d   = wr_ptr_q + PTR_W'(st_wr);
        occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
        // Registered from next occupancy, so it is exact and the tree needs no skid slot.
        in_avail_d = (occ_d < OCC_W'(DEPTH));
        cnt_d      = cnt_q + CNT_W'(push);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_avail_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_avail_q  <= in_avail_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage contents need no reset; pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (rst && st_wr) begin
            mem_q[wr_ptr_q] <= bus.in;
        end
    end

    assign bus.in_avail  = in_avail_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.occupancy = occ_q;
    assign bus.flit_cnt  = cnt_q;

    a_occ_range: assert property (@(posedge clk) disable iff (!rst)
        occ_q <= OCC_W'(DEPTH));
    a_head_live: assert property (@(posedge clk) disable iff (!rst)
        out_valid_q == (occ_q != '0));
endmodule

// File: tb/tb_ejection_buffer.sv
// Randomized scoreboard bench for ejection_buffer: a queue model of held flits is
// updated from sampled handshakes and compared against every output each cycle.
module tb_ejection_buffer;
    localparam int FW    = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ejection_buffer_if #(.FLIT_SIZE(FW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    ejection_buffer #(.FLIT_SIZE(FW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [FW-1:0]    exp_q[$];
    logic [CNT_W-1:0] exp_cnt   = '0;
    logic             exp_avail = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: model state describes the cycle before the next rising edge.
    always @(negedge clk) begin
        logic [FW-1:0] e;
        chk("in_avail",  64'(bus.in_avail),  64'(exp_avail));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        chk("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
        chk("flit_cnt",  64'(bus.flit_cnt),  64'(exp_cnt));
        if (!rst) begin
            exp_q.delete();
            exp_cnt   = '0;
            exp_avail = 1'b0;
        end else begin
            if (exp_q.size() != 0 && bus.out_avail) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.out), 64'(e));
            end
            if (bus.in_valid && exp_avail) begin
                exp_q.push_back(bus.in);
                exp_cnt = exp_cnt + 1'b1;
            end
            exp_avail = (exp_q.size() < DEPTH);
        end
    end

    bit acc;
    task automatic step();
        @(negedge clk);
        acc = rst && bus.in_valid && bus.in_avail;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] d;
        bit got;
        int pushed;

        bus.in        = 32'hDEAD_BEEF;
        bus.in_valid  = 1'b1;
        bus.out_avail = 1'b0;
        rst           = 1'b0;

        // Reset held for 3 cycles with a flit offered.
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_avail",  64'(bus.in_avail),  64'd0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_out",       64'(bus.out),       64'd0);
            chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
            chk("rst_flit_cnt",  64'(bus.flit_cnt),  64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("release_in_avail", 64'(bus.in_avail), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_release_in_avail", 64'(bus.in_avail), 64'd1);
        chk("post_release_flit_cnt", 64'(bus.flit_cnt), 64'd0);
        @(posedge clk); #1;

        // Fill with no pops, then drain while the remaining flits trickle in.
        d = 32'd1;
        bus.in = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (acc) d = d + 1;
            bus.in = d;
        end
        chk("fill_accepted_next", 64'(d), 64'd9);
        @(negedge clk);
        chk("full_occupancy", 64'(bus.occupancy), 64'd8);
        chk("full_in_avail",  64'(bus.in_avail),  64'd0);
        chk("full_flit_cnt",  64'(bus.flit_cnt),  64'd8);
        @(posedge clk); #1;
        bus.out_avail = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (acc) d = d + 1;
            bus.in = d;
            if (d > 32'd10) bus.in_valid = 1'b0;
        end
        chk("drain_all_accepted", 64'(d), 64'd11);

        // Bypass latency from empty.
        bus.in = 32'hAB;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bypass_push", 64'(acc), 64'd1);
        @(negedge clk);
        chk("bypass_valid", 64'(bus.out_valid), 64'd1);
        chk("bypass_data",  64'(bus.out),       64'hAB);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bypass_popped", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;

        // Streaming: every offer accepted, occupancy pinned at 1 by the monitor.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in = 32'h1000 + 32'(i);
            step();
            chk("stream_accept", 64'(acc), 64'd1);
        end
        bus.in_valid = 1'b0;
        repeat (3) step();

        // Random back-pressure.
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = ($urandom_range(99) < 70);
            bus.in        = $urandom;
            bus.out_avail = ($urandom_range(99) < 50);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_avail = 1'b1;
        repeat (12) step();

        // Mid-operation reset with 5 flits held.
        bus.out_avail = 1'b0;
        bus.in_valid  = 1'b1;
        pushed = 0;
        for (int k = 0; k < 20 && pushed < 5; k++) begin
            bus.in = 32'h200 + 32'(k);
            step();
            if (acc) pushed++;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_occupancy", 64'(bus.occupancy), 64'd5);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in = 32'h77;
        bus.in_valid = 1'b1;
        bus.out_avail = 1'b1;
        step();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.in = 32'h55;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = acc;
        end
        bus.in_valid = 1'b0;
        chk("post_rst_push", 64'(got), 64'd1);
        @(negedge clk);
        chk("post_rst_first_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_first_data",  64'(bus.out),       64'h55);
        @(posedge clk); #1;
        repeat (4) step();
        @(negedge clk);
        chk("final_occupancy", 64'(bus.occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
